// File: rtl/md_defs_pkg.sv
// md_defs: shared encodings and default latencies for the multiply/divide unit
package md_defs;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_compute.sv
// md_compute: combinational multiply/divide producing the {hi,lo} result pair
module md_compute
   import md_defs::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_res
);

   logic        w_sgn;
   logic [63:0] w_ma;
   logic [63:0] w_mb;
   logic [63:0] w_prod;
   logic [31:0] w_ua;
   logic [31:0] w_ub;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [31:0] w_qs;
   logic [31:0] w_rs;
   logic [63:0] w_div;

   // MULT and DIV are the signed variants (op bit 0 clear)
   assign w_sgn = ~i_op[0];

   // one multiplier serves both: sign-extend only for the signed op, keep the low 64 bits
   assign w_ma   = {{32{w_sgn & i_a[31]}}, i_a};
   assign w_mb   = {{32{w_sgn & i_b[31]}}, i_b};
   assign w_prod = w_ma * w_mb;

   // signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
   assign w_ua = (w_sgn & i_a[31]) ? -i_a : i_a;
   assign w_ub = (w_sgn & i_b[31]) ? -i_b : i_b;
   assign w_q  = w_ua / w_ub;
   assign w_r  = w_ua % w_ub;
   assign w_qs = (w_sgn & (i_a[31] ^ i_b[31])) ? -w_q : w_q;
   assign w_rs = (w_sgn & i_a[31]) ? -w_r : w_r;

   // divide by zero: LO all ones, HI keeps the dividend
   assign w_div = (i_b == 32'd0) ? {i_a, 32'hFFFF_FFFF} : {w_rs, w_qs};

   assign o_res = i_op[2] ? 64'd0 : (i_op[1] ? w_div : w_prod);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mul_div_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   logic [0:0]  r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_phi;
   logic [31:0] r_plo;
   logic [63:0] w_res;
   logic        w_idle_start;
   logic [3:0]  w_lat;

   md_compute u_compute (
      .i_op  (md_op),
      .i_a   (A),
      .i_b   (B),
      .o_res (w_res)
   );

   assign w_idle_start = start & (r_state == ST_IDLE);
   assign w_lat        = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

   // FSM: capture result at start, count down the latency, commit HI/LO when cnt reaches 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_phi   <= 32'd0;
         r_plo   <= 32'd0;
      end else if (r_state == ST_RUN) begin
         if (r_cnt == 4'd1) begin
            r_hi    <= r_phi;
            r_lo    <= r_plo;
            r_cnt   <= 4'd0;
            r_state <= ST_IDLE;
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end else if (w_idle_start && !md_op[2]) begin
         r_phi   <= w_res[63:32];
         r_plo   <= w_res[31:0];
         r_cnt   <= w_lat;
         r_state <= ST_RUN;
      end else if (w_idle_start && md_op == MD_MTHI) begin
         r_hi <= A;
      end else if (w_idle_start && md_op == MD_MTLO) begin
         r_lo <= A;
      end
   end

   assign busy = (r_state == ST_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for the multiply/divide unit
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks;
   int failures;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .md_op (md_op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulse start for one edge; operands are scrambled afterwards to prove they are captured
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
   endtask

   // count edges until busy drops, bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
      checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mult;
      int n;
      issue(3'b000, 32'hFFFF_FFFE, 32'd3);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_start got=%0b exp=1", busy); end
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL mult_latency got=%0d exp=5", n); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
   endtask

   task automatic test_multu;
      int n;
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL multu_latency got=%0d exp=5", n); end
      checks++; if (HI !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
      checks++; if (LO !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
   endtask

   task automatic test_div;
      int n;
      issue(3'b010, 32'hFFFF_FFF9, 32'd2);
      checks++; if (HI !== 32'hFFFF_FFFE) begin failures++; $display("FAIL div_hi_held got=%h exp=fffffffe", HI); end
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL div_latency got=%0d exp=10", n); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
   endtask

   task automatic test_div_by_zero;
      int n;
      issue(3'b011, 32'd7, 32'd0);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divu0_latency got=%0d exp=10", n); end
      checks++; if (LO !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", LO); end
      checks++; if (HI !== 32'd7) begin failures++; $display("FAIL divu0_hi got=%h exp=00000007", HI); end
   endtask

   task automatic test_div_overflow;
      int n;
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divovf_latency got=%0d exp=10", n); end
      checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
      checks++; if (HI !== 32'd0) begin failures++; $display("FAIL divovf_hi got=%h exp=00000000", HI); end
   endtask

   task automatic test_ignore_while_busy;
      int n;
      issue(3'b011, 32'd100, 32'd7);
      @(posedge clk);
      @(posedge clk);
      issue(3'b100, 32'h1234, 32'd0);
      checks++; if (HI !== 32'd0) begin failures++; $display("FAIL ignore_hi_unchanged got=%h exp=00000000", HI); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%0b exp=1", busy); end
      wait_idle(n);
      checks++; if (n != 7) begin failures++; $display("FAIL ignore_remaining got=%0d exp=7", n); end
      checks++; if (HI !== 32'd2) begin failures++; $display("FAIL ignore_hi got=%h exp=00000002", HI); end
      checks++; if (LO !== 32'd14) begin failures++; $display("FAIL ignore_lo got=%h exp=0000000e", LO); end
      issue(3'b101, 32'd5, 32'd0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%0b exp=0", busy); end
      checks++; if (LO !== 32'd5) begin failures++; $display("FAIL mtlo_lo got=%h exp=00000005", LO); end
      checks++; if (HI !== 32'd2) begin failures++; $display("FAIL mtlo_hi got=%h exp=00000002", HI); end
      issue(3'b110, 32'hDEAD_BEEF, 32'd1);
      checks++; if (busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd5) begin failures++; $display("FAIL reserved_op got=%0b/%h/%h exp=0/00000002/00000005", busy, HI, LO); end
   endtask

   task automatic test_async_reset;
      issue(3'b000, 32'd3, 32'd4);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
      checks++; if (HI !== 32'd0) begin failures++; $display("FAIL arst_hi got=%h exp=00000000", HI); end
      checks++; if (LO !== 32'd0) begin failures++; $display("FAIL arst_lo got=%h exp=00000000", LO); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL arst_late_commit cyc=%0d got=%0b/%h/%h exp=0/00000000/00000000", i, busy, HI, LO); end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      start    = 1'b0;
      md_op    = 3'b000;
      A        = 32'd0;
      B        = 32'd0;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_by_zero();
      test_div_overflow();
      test_ignore_while_busy();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
